// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: one read per core loop (ADDR->DATA->DELIVER->WAIT_WB),
// handing instr/pc to decode and halting with a sticky error code on bus/alignment/timeout faults.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        ifu_valid,
    input  logic        idu_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        wbu_valid,
    input  logic [31:0] next_pc,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [31:0] fetch_cnt,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where both valid and
    // ready are high; valid is never withdrawn and its payload never changes
    // before that edge.
    typedef enum logic [2:0] {
        ST_ADDR    = 3'd0,
        ST_DATA    = 3'd1,
        ST_DELIVER = 3'd2,
        ST_WAIT_WB = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [1:0]  ERR_NONE = 2'b00;
    localparam logic [1:0]  ERR_BUS  = 2'b01;
    localparam logic [1:0]  ERR_ALGN = 2'b10;
    localparam logic [1:0]  ERR_TMO  = 2'b11;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fetch_cnt_d = fetch_cnt_q;
        err_code_d  = err_code_q;
        fetch_err_d = fetch_err_q;
        tmo_cnt_d   = 16'd0;
        case (state_q)
            ST_ADDR: begin
                if (arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rvalid) begin
                    if (rresp == 2'b00) begin
                        instr_d = rdata;
                        state_d = ST_DELIVER;
                    end else begin
                        err_code_d  = ERR_BUS;
                        fetch_err_d = 1'b1;
                        state_d     = ST_HALT;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // This idle cycle is the TIMEOUT-th one spent waiting.
                    err_code_d  = ERR_TMO;
                    fetch_err_d = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ST_DELIVER: begin
                if (idu_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = ST_WAIT_WB;
                end
            end
            ST_WAIT_WB: begin
                if (wbu_valid) begin
                    pc_d = next_pc;
                    if (next_pc[1:0] != 2'b00) begin
                        err_code_d  = ERR_ALGN;
                        fetch_err_d = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ADDR;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            fetch_cnt_q <= 32'h0;
            err_code_q  <= ERR_NONE;
            fetch_err_q <= 1'b0;
            tmo_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            fetch_cnt_q <= fetch_cnt_d;
            err_code_q  <= err_code_d;
            fetch_err_q <= fetch_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Handshake outputs depend on state only, gated off while reset is held.
    assign arvalid   = !rst && (state_q == ST_ADDR);
    assign rready    = !rst && (state_q == ST_DATA);
    assign ifu_valid = !rst && (state_q == ST_DELIVER);

    assign araddr    = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign fetch_cnt = fetch_cnt_q;
    assign err_code  = err_code_q;
    assign fetch_err = fetch_err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Instruction fetch unit that feeds the decode stage of the multi-cycle core. Issues one instruction read per cycle of the core loop over an AXI-lite-style read channel. Hands instr/pc to decode via the ifu_valid/idu_ready handshake, then waits for writeback to return the next PC. Detects bus errors, misaligned PCs and response timeouts, and halts with a sticky error code.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset.
TIMEOUT, 255, max cycles in DATA state without rvalid before a timeout error (1..65535).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
araddr  out  32  read address (= pc)
arvalid  out  1  read address valid
arready  in  1  memory accepts address
rdata  in  32  read data
rresp  in  2  read response; 2'b00 = OKAY, others = error
rvalid  in  1  read data valid
rready  out  1  fetch accepts data
ifu_valid  out  1  instr/pc valid to decode
idu_ready  in  1  decode accepts instr
instr  out  32  fetched instruction
pc  out  32  address of instr
wbu_valid  in  1  writeback done, next_pc valid
next_pc  in  32  PC of next instruction
fetch_err  out  1  sticky error flag, core halted
err_code  out  2  00 none, 01 bus error, 10 misaligned PC, 11 timeout
fetch_cnt  out  32  count of delivered instructions

Behaviour:
- Reset (rst=1 at posedge):
  - state=ADDR, pc=RESET_PC, instr=32'h0, fetch_err=0, err_code=00, fetch_cnt=0, timeout counter=0.
  - While rst is high, arvalid, rready and ifu_valid are forced 0 combinationally.
  - Reset mid-transaction abandons the transaction. A late rvalid arriving after reset is ignored because rready=0 in ADDR.
- States: ADDR, DATA, DELIVER, WAIT_WB, HALT. Handshake outputs are a pure function of state; no outputs depend combinationally on inputs.
- ADDR:
  - arvalid=1, araddr=pc.
  - On arready=1 in the same cycle, go to DATA; the handshake completes in the cycle arvalid first rises if arready is already high.
  - araddr stays stable while arvalid=1 and arready=0.
- DATA:
  - rready=1; timeout counter increments each cycle.
  - rvalid=1 and rresp=00: instr<=rdata, clear counter, go to DELIVER.
  - rvalid=1 and rresp!=00: go to HALT, err_code=01.
  - Counter reaches TIMEOUT with no rvalid: go to HALT, err_code=11.
  - rvalid outside DATA is ignored.
- DELIVER:
  - ifu_valid=1; instr and pc held stable until the handshake completes.
  - On idu_ready=1: fetch_cnt<=fetch_cnt+1 (wraps 2^32-1 to 0), go to WAIT_WB.
- WAIT_WB:
  - On wbu_valid=1 with next_pc[1:0]==00: pc<=next_pc, go to ADDR.
  - On wbu_valid=1 with next_pc[1:0]!=00: pc<=next_pc, go to HALT, err_code=10.
  - wbu_valid in any other state is ignored (no pc update).
- HALT:
  - fetch_err=1; all handshake outputs 0.
  - Remains in HALT until rst. err_code holds the first error only.
- Minimum loop latency with zero-wait memory, decode and writeback: ADDR→DATA→DELIVER→WAIT_WB→ADDR = 4 cycles per instruction.
- instr, pc and fetch_cnt are registered outputs; araddr = pc.

Test Plan:
- Normal fetch: release rst, memory arready=1 and rvalid=1 next cycle with rdata=32'h00100093 and rresp=00, idu_ready=1, wbu_valid=1 with next_pc=32'h8000_0004 -> araddr=32'h8000_0000; ifu_valid one cycle with instr=32'h00100093 and pc=32'h8000_0000; second arvalid shows araddr=32'h8000_0004; fetch_cnt=1.
- Backpressure: hold arready=0 for 3 cycles, then rvalid delayed 5 cycles, then idu_ready=0 for 4 cycles -> araddr, instr and pc stable throughout; ifu_valid stays 1 until idu_ready; exactly one fetch_cnt increment.
- Bus error: rvalid=1 with rresp=2'b10 -> fetch_err=1, err_code=01, ifu_valid never asserted, no further arvalid.
- Misaligned redirect: wbu_valid=1 with next_pc=32'h8000_0006 -> err_code=10, HALT, no arvalid.
- Timeout (TIMEOUT=4): arready accepted, rvalid never asserted -> HALT with err_code=11 after 4 cycles in DATA; a later rvalid pulse is ignored.
- Reset mid-op and ignored events: assert rst while in DATA, pulse wbu_valid while in ADDR -> after reset pc=RESET_PC, err_code=00, fetch_cnt=0; stray wbu_valid leaves pc unchanged.
